mmio_arbiter: RTL

- Two-master, one-slave arbiter for the CPU MMIO bus. The slave side has the same word-addressed addr/data/mask/wren signals as cpu_top's MMIO port, plus a read strobe.
- Shares the single MMIO slave path between the CPU core (m0) and a second requester (m1, debug/DMA). Uses round-robin grant, registered issue, and pipelined read-data return routed to the issuing master.

---
 rtl/mmio_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: two-master, one-slave arbiter for the CPU MMIO bus.
//
// Shares a single word-addressed MMIO slave between m0 (CPU core) and m1
// (debug/DMA). Arbitration is combinational with a round-robin priority
// pointer; the winning access is issued to the slave one cycle later from
// registers. Reads are tagged with the issuing master and the slave data is
// routed back RD_LAT+1 cycles after the read strobe.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_mX_req/addr/data/mask/wren   master X request and access fields
//   o_mX_gnt                       master X request accepted this cycle
//   o_mX_rvalid/rdata              master X read response
//   o_mmio_addr/data/mask          slave access fields (held when idle)
//   o_mmio_wren/rden               one-cycle slave write/read strobes
//   i_mmio_data                    slave read data, RD_LAT cycles after rden
module mmio_arbiter #(
    parameter int          ADDR_W = 30,
    parameter int          DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_m0_req,
    input  logic [ADDR_W-1:0]   i_m0_addr,
    input  logic [DATA_W-1:0]   i_m0_data,
    input  logic [DATA_W/8-1:0] i_m0_mask,
    input  logic                i_m0_wren,
    output logic                o_m0_gnt,
    output logic                o_m0_rvalid,
    output logic [DATA_W-1:0]   o_m0_rdata,
    input  logic                i_m1_req,
    input  logic [ADDR_W-1:0]   i_m1_addr,
    input  logic [DATA_W-1:0]   i_m1_data,
    input  logic [DATA_W/8-1:0] i_m1_mask,
    input  logic                i_m1_wren,
    output logic                o_m1_gnt,
    output logic                o_m1_rvalid,
    output logic [DATA_W-1:0]   o_m1_rdata,
    output logic [ADDR_W-1:0]   o_mmio_addr,
    output logic [DATA_W-1:0]   o_mmio_data,
    output logic [DATA_W/8-1:0] o_mmio_mask,
    output logic                o_mmio_wren,
    output logic                o_mmio_rden,
    input  logic [DATA_W-1:0]   i_mmio_data
);

    typedef enum logic {
        PRIO_M0 = 1'b0,
        PRIO_M1 = 1'b1
    } prio_t;

    prio_t             r_prio;
    logic              r_iss_id;     // master owning the access on the strobes
    logic [RD_LAT-1:0] r_tag_v;      // read-tag pipeline: valid bits
    logic [RD_LAT-1:0] r_tag_id;     // read-tag pipeline: master ids
    logic [RD_LAT:0]   w_tag_v_next;
    logic [RD_LAT:0]   w_tag_id_next;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_tag_hit;
    logic              w_tag_m1;

    // Grants are suppressed while in reset so nothing is consumed.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (i_m0_req && (!i_m1_req || r_prio == PRIO_M0)) begin
                w_gnt0 = 1'b1;
            end else if (i_m1_req) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign o_m0_gnt = w_gnt0;
    assign o_m1_gnt = w_gnt1;

    // The strobe cycle feeds stage 0; the last stage lines up with the cycle
    // in which the slave presents the read data.
    assign w_tag_v_next  = {r_tag_v,  o_mmio_rden};
    assign w_tag_id_next = {r_tag_id, r_iss_id};
    assign w_tag_hit     = r_tag_v[RD_LAT-1];
    assign w_tag_m1      = r_tag_id[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio      <= PRIO_M0;
            r_iss_id    <= 1'b0;
            r_tag_v     <= '0;
            r_tag_id    <= '0;
            o_mmio_addr <= '0;
            o_mmio_data <= '0;
            o_mmio_mask <= '0;
            o_mmio_wren <= 1'b0;
            o_mmio_rden <= 1'b0;
            o_m0_rvalid <= 1'b0;
            o_m1_rvalid <= 1'b0;
            o_m0_rdata  <= '0;
            o_m1_rdata  <= '0;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_prio      <= w_gnt0 ? PRIO_M1 : PRIO_M0;
                r_iss_id    <= w_gnt1;
                o_mmio_addr <= w_gnt0 ? i_m0_addr : i_m1_addr;
                o_mmio_data <= w_gnt0 ? i_m0_data : i_m1_data;
                o_mmio_mask <= w_gnt0 ? i_m0_mask : i_m1_mask;
                o_mmio_wren <= w_gnt0 ? i_m0_wren : i_m1_wren;
                o_mmio_rden <= w_gnt0 ? !i_m0_wren : !i_m1_wren;
            end else begin
                o_mmio_wren <= 1'b0;
                o_mmio_rden <= 1'b0;
            end

            r_tag_v  <= w_tag_v_next[RD_LAT-1:0];
            r_tag_id <= w_tag_id_next[RD_LAT-1:0];

            o_m0_rvalid <= w_tag_hit && !w_tag_m1;
            o_m1_rvalid <= w_tag_hit && w_tag_m1;
            if (w_tag_hit && !w_tag_m1) begin
                o_m0_rdata <= i_mmio_data;
            end
            if (w_tag_hit && w_tag_m1) begin
                o_m1_rdata <= i_mmio_data;
            end
        end
    end

endmodule
